avalon_multi_timer: RTL

Multi-channel Avalon-MM interval timer: NUM_CH independent down-counters of CNT_W bits, each with one-shot or continuous mode, software start/stop, timeout flag with maskable interrupt, and an optional snapshot register. It sits on the system Avalon-MM interconnect as a single slave and drives one combined `irq` plus a per-channel interrupt vector for the interrupt controller.

---
 rtl/timer_pkg.sv | 15 +
 rtl/timer_channel.sv | 87 ++++++++
 rtl/avalon_multi_timer.sv | 67 ++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared register offsets and bit positions for the Avalon-MM multi-channel timer.
package timer_pkg;
  localparam logic [1:0] REG_STATUS   = 2'd0;
  localparam logic [1:0] REG_CONTROL  = 2'd1;
  localparam logic [1:0] REG_PERIOD   = 2'd2;
  localparam logic [1:0] REG_SNAPSHOT = 2'd3;

  localparam int STAT_TO    = 0;
  localparam int STAT_RUN   = 1;

  localparam int CTRL_ITO   = 0;
  localparam int CTRL_CONT  = 1;
  localparam int CTRL_START = 2;
  localparam int CTRL_STOP  = 3;
endpackage

// File: rtl/timer_channel.sv
// One timer channel: down-counter, RUN/CONT/ITO/TO bits, period and snapshot.
// Snapshot register exists only when TIMER_SNAPSHOT_EN is defined.
module timer_channel
  import timer_pkg::*;
#(
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'd1649999,
  parameter int          AUTO_START   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_we,
  input  logic [1:0]  i_reg,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_irq
);
  logic [CNT_W-1:0] r_cnt, r_period;
  logic             r_run, r_cont, r_ito, r_to;
  logic             w_tmo, w_wr_stat, w_wr_ctrl, w_wr_per;
  logic [31:0]      w_snap;

  assign w_tmo     = r_run && (r_cnt == '0);
  assign w_wr_stat = i_we && (i_reg == REG_STATUS);
  assign w_wr_ctrl = i_we && (i_reg == REG_CONTROL);
  assign w_wr_per  = i_we && (i_reg == REG_PERIOD);

  // Later assignments override earlier ones: software writes beat the
  // timeout's own RUN/counter update, while TO always keeps a timeout.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= CNT_W'(RESET_PERIOD);
      r_period <= CNT_W'(RESET_PERIOD);
      r_run    <= (AUTO_START != 0);
      r_cont   <= (AUTO_START != 0);
      r_ito    <= 1'b0;
      r_to     <= 1'b0;
    end else begin
      if (r_run) r_cnt <= w_tmo ? r_period : r_cnt - 1'b1;
      if (w_tmo && !r_cont) r_run <= 1'b0;
      r_to <= w_tmo | (r_to & ~w_wr_stat);
      if (w_wr_ctrl) begin
        r_ito  <= i_wdata[CTRL_ITO];
        r_cont <= i_wdata[CTRL_CONT];
        if (i_wdata[CTRL_STOP])       r_run <= 1'b0;
        else if (i_wdata[CTRL_START]) r_run <= 1'b1;
      end
      if (w_wr_per) begin
        r_period <= i_wdata[CNT_W-1:0];
        r_cnt    <= i_wdata[CNT_W-1:0];
      end
    end
  end

`ifdef TIMER_SNAPSHOT_EN
  logic [CNT_W-1:0] r_snap;
  logic             w_wr_snap;
  assign w_wr_snap = i_we && (i_reg == REG_SNAPSHOT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_snap <= '0;
    else if (w_wr_snap) r_snap <= r_cnt;
  end
  assign w_snap = 32'(r_snap);
`else
  assign w_snap = '0;
`endif

  always_comb begin
    o_rdata = '0;
    case (i_reg)
      REG_STATUS: begin
        o_rdata[STAT_TO]  = r_to;
        o_rdata[STAT_RUN] = r_run;
      end
      REG_CONTROL: begin
        o_rdata[CTRL_ITO]  = r_ito;
        o_rdata[CTRL_CONT] = r_cont;
      end
      REG_PERIOD:   o_rdata = 32'(r_period);
      REG_SNAPSHOT: o_rdata = w_snap;
      default:      o_rdata = '0;
    endcase
  end

  assign o_irq = r_to & r_ito;
endmodule

// File: rtl/avalon_multi_timer.sv
// Multi-channel Avalon-MM interval timer: address decode, read mux, irq OR.
// Optional snapshot register per channel via TIMER_SNAPSHOT_EN.
module avalon_multi_timer
  import timer_pkg::*;
#(
  parameter int          NUM_CH       = 4,
  parameter int          CNT_W        = 32,
  parameter logic [31:0] RESET_PERIOD = 32'd1649999,
  parameter int          AUTO_START   = 1,
  parameter int          ADDR_W       = $clog2(NUM_CH) + 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] irq_ch,
  output logic              irq
);
  logic [2:0]  w_ch;
  logic        w_wr;
  logic [31:0] w_rd [NUM_CH];
  logic [31:0] w_sel;

  // Single-channel builds have no channel field in the address.
  generate
    if (ADDR_W > 2) begin : g_ch
      assign w_ch = 3'(address[ADDR_W-1:2]);
    end else begin : g_noch
      assign w_ch = '0;
    end
  endgenerate

  assign w_wr = chipselect & ~write_n;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    timer_channel #(
      .CNT_W       (CNT_W),
      .RESET_PERIOD(RESET_PERIOD),
      .AUTO_START  (AUTO_START)
    ) u_ch (
      .clk    (clk),
      .reset_n(reset_n),
      .i_we   (w_wr && (w_ch == 3'(c))),
      .i_reg  (address[1:0]),
      .i_wdata(writedata),
      .o_rdata(w_rd[c]),
      .o_irq  (irq_ch[c])
    );
  end

  // Unpopulated channel indices fall through to zero.
  always_comb begin
    w_sel = '0;
    for (int c = 0; c < NUM_CH; c++)
      if (w_ch == 3'(c)) w_sel = w_rd[c];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= w_sel;
  end

  assign irq = |irq_ch;
endmodule
